lsu_data_port: RTL and testbench

- Load/store unit: the initiator on the core-to-data-memory interface. The data memory sized by DATA_MEM_SIZE_BYTES is the responder.
- Takes byte/half/word load-store requests from the core decoder and produces the memory request, byte enables and replicated write data.
- Holds the core stalled until the memory answers, then returns sign- or zero-extended load data.
- Sits between the core datapath and the data memory, or the memory-side interconnect.

---
 rtl/lsu_data_port.sv | 166 ++++++++++++++++
 tb/tb_lsu_data_port.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_data_port.sv
// Load/store data port: checks, issues and completes one core access at a time
// against a ready-handshake data memory, returning extended load data.
module lsu_data_port #(
   parameter int unsigned DATA_MEM_SIZE_BYTES = 2048,
   parameter int unsigned TIMEOUT_CYCLES      = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        core_req_i,
   input  logic        core_we_i,
   input  logic [2:0]  core_size_i,
   input  logic [31:0] core_addr_i,
   input  logic [31:0] core_wd_i,
   output logic [31:0] core_rd_o,
   output logic        core_stall_o,
   output logic        core_fault_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wd_o,
   input  logic [31:0] mem_rd_i,
   input  logic        mem_ready_i
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [0:0]  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] rd_q, rd_d;

   logic        size_ok, is_half, is_word, bad;
   logic [3:0]  be;
   logic [31:0] wd, rd_shift, ext;
   logic [7:0]  bsel;
   logic [15:0] hsel;
   logic        req, stall, fault;
   logic [31:0] rd_out;

   always_comb begin
      size_ok = 1'b0;
      case (core_size_i)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: size_ok = 1'b1;
         default:                                size_ok = 1'b0;
      endcase
      is_half = (core_size_i[1:0] == 2'b01);
      is_word = (core_size_i == 3'b010);
      bad = !size_ok
         || (is_half && core_addr_i[0])
         || (is_word && (core_addr_i[1:0] != 2'b00))
         || (core_addr_i >= 32'(DATA_MEM_SIZE_BYTES));
   end

   // Byte-lane enables and lane-replicated store data.
   always_comb begin
      be = 4'b1111;
      wd = core_wd_i;
      case (core_size_i[1:0])
         2'b00: begin
            be = 4'b0001 << core_addr_i[1:0];
            wd = {4{core_wd_i[7:0]}};
         end
         2'b01: begin
            be = core_addr_i[1] ? 4'b1100 : 4'b0011;
            wd = {2{core_wd_i[15:0]}};
         end
         default: begin
            be = 4'b1111;
            wd = core_wd_i;
         end
      endcase
   end

   always_comb begin
      rd_shift = mem_rd_i >> {core_addr_i[1:0], 3'b000};
      bsel     = rd_shift[7:0];
      hsel     = core_addr_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
      case (core_size_i)
         3'b000:  ext = {{24{bsel[7]}}, bsel};
         3'b100:  ext = {24'd0, bsel};
         3'b001:  ext = {{16{hsel[15]}}, hsel};
         3'b101:  ext = {16'd0, hsel};
         default: ext = mem_rd_i;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_d    = rd_q;
      req     = 1'b0;
      stall   = 1'b0;
      fault   = 1'b0;
      rd_out  = rd_q;
      case (state_q)
         S_IDLE: begin
            if (core_req_i && bad) begin
               fault = 1'b1;
            end else if (core_req_i) begin
               req     = 1'b1;
               stall   = 1'b1;
               state_d = S_BUSY;
               cnt_d   = 8'd0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_BUSY: begin
            // Ready wins over timeout when both land on the same cycle.
            if (mem_ready_i) begin
               req     = 1'b1;
               state_d = S_IDLE;
               if (!core_we_i) begin
                  rd_d   = ext;
                  rd_out = ext;
               end else begin
                  rd_d = rd_q;
               end
            end else if (cnt_q == CNT_LAST) begin
               fault   = 1'b1;
               state_d = S_IDLE;
            end else begin
               req   = 1'b1;
               stall = 1'b1;
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (rst_i) begin
         state_d = S_IDLE;
         cnt_d   = 8'd0;
         rd_d    = 32'd0;
         req     = 1'b0;
         stall   = 1'b0;
         fault   = 1'b0;
         rd_out  = 32'd0;
      end else begin
         rd_out = rd_out;
      end
   end

   assign core_rd_o    = rd_out;
   assign core_stall_o = stall;
   assign core_fault_o = fault;
   assign mem_req_o    = req;
   assign mem_we_o     = req && core_we_i;
   assign mem_be_o     = req ? be : 4'b0000;
   assign mem_wd_o     = req ? wd : 32'd0;
   assign mem_addr_o   = core_addr_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         rd_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
      end
   end

endmodule

// File: tb/tb_lsu_data_port.sv
// Directed bench for lsu_data_port: vector table, timeout, reset-in-BUSY and
// store/load round trips against a small word memory with variable latency.
module tb_lsu_data_port;

   logic        clk = 1'b0;
   logic        rst_i, core_req_i, core_we_i, mem_ready_i;
   logic [2:0]  core_size_i;
   logic [31:0] core_addr_i, core_wd_i, mem_rd_i;
   logic [31:0] core_rd_o, mem_addr_o, mem_wd_o;
   logic        core_stall_o, core_fault_o, mem_req_o, mem_we_o;
   logic [3:0]  mem_be_o;

   int errors = 0;
   int checks = 0;
   logic [31:0] mem [0:511];

   typedef struct {
      logic        we;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rdata;
      logic        fault;
      logic [3:0]  be;
      logic [31:0] mwd;
      logic [31:0] rd;
   } vec_t;

   vec_t vecs [16];

   lsu_data_port #(.DATA_MEM_SIZE_BYTES(2048), .TIMEOUT_CYCLES(4)) dut (
      .clk_i(clk), .rst_i(rst_i), .core_req_i(core_req_i), .core_we_i(core_we_i),
      .core_size_i(core_size_i), .core_addr_i(core_addr_i), .core_wd_i(core_wd_i),
      .core_rd_o(core_rd_o), .core_stall_o(core_stall_o), .core_fault_o(core_fault_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
      .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i),
      .mem_ready_i(mem_ready_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      @(negedge clk);
      core_req_i = 1'b1; core_we_i = v.we; core_size_i = v.size;
      core_addr_i = v.addr; core_wd_i = v.wd; mem_ready_i = 1'b0;
      #1;
      chk("vec_fault", 32'(core_fault_o), 32'(v.fault));
      chk("vec_req", 32'(mem_req_o), 32'(!v.fault));
      chk("vec_stall", 32'(core_stall_o), 32'(!v.fault));
      chk("vec_we", 32'(mem_we_o), 32'(v.we && !v.fault));
      if (v.fault) begin
         @(negedge clk);
         core_req_i = 1'b0;
         #1 chk("vec_fault_clear", 32'(core_fault_o), 32'd0);
      end else begin
         chk("vec_be", 32'(mem_be_o), 32'(v.be));
         if (v.we) chk("vec_wd", mem_wd_o, v.mwd);
         @(negedge clk);
         mem_ready_i = 1'b1; mem_rd_i = v.rdata;
         #1;
         chk("vec_ready_stall", 32'(core_stall_o), 32'd0);
         chk("vec_ready_be", 32'(mem_be_o), 32'(v.be));
         if (!v.we) chk("vec_rd", core_rd_o, v.rd);
         @(negedge clk);
         core_req_i = 1'b0; mem_ready_i = 1'b0; mem_rd_i = 32'd0;
         #1;
         chk("vec_idle_req", 32'(mem_req_o), 32'd0);
         if (!v.we) chk("vec_rd_held", core_rd_o, v.rd);
      end
   endtask

   task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wd, input int lat, output logic [31:0] rd);
      @(negedge clk);
      core_req_i = 1'b1; core_we_i = we; core_size_i = size;
      core_addr_i = addr; core_wd_i = wd; mem_ready_i = 1'b0;
      #1 chk("acc_issue_stall", 32'(core_stall_o), 32'd1);
      for (int k = 1; k < lat; k++) begin
         @(negedge clk);
         #1 chk("acc_wait_stall", 32'(core_stall_o), 32'd1);
      end
      @(negedge clk);
      mem_ready_i = 1'b1; mem_rd_i = mem[addr[10:2]];
      #1;
      chk("acc_ready_stall", 32'(core_stall_o), 32'd0);
      rd = core_rd_o;
      if (we) begin
         for (int b = 0; b < 4; b++)
            if (mem_be_o[b]) mem[addr[10:2]][8*b +: 8] = mem_wd_o[8*b +: 8];
      end
      @(negedge clk);
      core_req_i = 1'b0; mem_ready_i = 1'b0; mem_rd_i = 32'd0;
   endtask

   initial begin
      logic [31:0] rd, data, addr, expv;
      int sz;
      logic uns;

      //             we    size    addr          wd            rdata         flt   be       mwd           rd
      vecs[0]  = '{1'b0, 3'b000, 32'h00000103, 32'h0,        32'h80FF7F01, 1'b0, 4'b1000, 32'h0,        32'hFFFFFF80};
      vecs[1]  = '{1'b0, 3'b100, 32'h00000103, 32'h0,        32'h80FF7F01, 1'b0, 4'b1000, 32'h0,        32'h00000080};
      vecs[2]  = '{1'b1, 3'b001, 32'h00000006, 32'h1234ABCD, 32'h0,        1'b0, 4'b1100, 32'hABCDABCD, 32'h0};
      vecs[3]  = '{1'b0, 3'b010, 32'h00000002, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
      vecs[4]  = '{1'b1, 3'b010, 32'h00000800, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
      vecs[5]  = '{1'b0, 3'b011, 32'h00000010, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
      vecs[6]  = '{1'b0, 3'b001, 32'h00000002, 32'h0,        32'h80FF7F01, 1'b0, 4'b1100, 32'h0,        32'hFFFF80FF};
      vecs[7]  = '{1'b0, 3'b101, 32'h00000000, 32'h0,        32'h1234F00D, 1'b0, 4'b0011, 32'h0,        32'h0000F00D};
      vecs[8]  = '{1'b0, 3'b000, 32'h00000001, 32'h0,        32'h80FF7F01, 1'b0, 4'b0010, 32'h0,        32'h0000007F};
      vecs[9]  = '{1'b0, 3'b010, 32'h000007FC, 32'h0,        32'hDEADBEEF, 1'b0, 4'b1111, 32'h0,        32'hDEADBEEF};
      vecs[10] = '{1'b1, 3'b000, 32'h00000005, 32'h000000A5, 32'h0,        1'b0, 4'b0010, 32'hA5A5A5A5, 32'h0};
      vecs[11] = '{1'b0, 3'b001, 32'h00000001, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
      vecs[12] = '{1'b1, 3'b010, 32'h00000008, 32'hCAFEF00D, 32'h0,        1'b0, 4'b1111, 32'hCAFEF00D, 32'h0};
      vecs[13] = '{1'b0, 3'b110, 32'h00000000, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
      vecs[14] = '{1'b0, 3'b100, 32'h000007FF, 32'h0,        32'h11223344, 1'b0, 4'b1000, 32'h0,        32'h00000011};
      vecs[15] = '{1'b0, 3'b010, 32'hFFFFFFFC, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};

      for (int i = 0; i < 512; i++) mem[i] = 32'd0;
      mem[4] = 32'h0BADF00D;
      mem[8] = 32'h5555AAAA;

      rst_i = 1'b1; core_req_i = 1'b0; core_we_i = 1'b0; core_size_i = 3'b000;
      core_addr_i = 32'd0; core_wd_i = 32'd0; mem_rd_i = 32'd0; mem_ready_i = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req", 32'(mem_req_o), 32'd0);
      chk("rst_stall", 32'(core_stall_o), 32'd0);
      chk("rst_fault", 32'(core_fault_o), 32'd0);
      chk("rst_rd", core_rd_o, 32'd0);
      @(negedge clk);
      rst_i = 1'b0;

      for (int i = 0; i < 16; i++) run_vec(vecs[i]);

      // Timeout: four stall cycles, then a single fault cycle with the request dropped.
      @(negedge clk);
      core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'b010; core_addr_i = 32'h10;
      #1 chk("to_stall_0", 32'(core_stall_o), 32'd1);
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         #1;
         chk("to_stall", 32'(core_stall_o), 32'd1);
         chk("to_no_fault", 32'(core_fault_o), 32'd0);
      end
      @(negedge clk);
      #1;
      chk("to_fault", 32'(core_fault_o), 32'd1);
      chk("to_fault_stall", 32'(core_stall_o), 32'd0);
      chk("to_fault_req", 32'(mem_req_o), 32'd0);
      @(negedge clk);
      core_req_i = 1'b0;
      #1;
      chk("to_after_fault", 32'(core_fault_o), 32'd0);
      chk("to_after_req", 32'(mem_req_o), 32'd0);
      access(1'b0, 3'b010, 32'h10, 32'd0, 2, rd);
      chk("to_retry_rd", rd, 32'h0BADF00D);

      // Reset while BUSY, then a stale ready.
      @(negedge clk);
      core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'b010; core_addr_i = 32'h20;
      @(negedge clk);
      rst_i = 1'b1; core_req_i = 1'b0;
      #1;
      chk("rb_req", 32'(mem_req_o), 32'd0);
      chk("rb_stall", 32'(core_stall_o), 32'd0);
      chk("rb_rd", core_rd_o, 32'd0);
      @(negedge clk);
      rst_i = 1'b0; mem_ready_i = 1'b1; mem_rd_i = 32'hFFFFFFFF;
      #1;
      chk("rb_stale_req", 32'(mem_req_o), 32'd0);
      chk("rb_stale_stall", 32'(core_stall_o), 32'd0);
      chk("rb_stale_rd", core_rd_o, 32'd0);
      @(negedge clk);
      mem_ready_i = 1'b0; mem_rd_i = 32'd0;
      #1 chk("rb_rd_after", core_rd_o, 32'd0);

      // Store then load back the same location with random sizes and latencies.
      for (int i = 0; i < 16; i++) begin
         sz   = int'($urandom_range(0, 2));
         data = $urandom;
         addr = 32'h100 + 32'(i * 4);
         if (sz == 0) addr = addr + 32'($urandom_range(0, 3));
         if (sz == 1) addr = addr + 32'(2 * $urandom_range(0, 1));
         uns  = (sz < 2) && ($urandom_range(0, 1) == 1);
         access(1'b1, 3'(sz), addr, data, int'($urandom_range(1, 4)), rd);
         access(1'b0, {uns, 2'(sz)}, addr, 32'd0, int'($urandom_range(1, 4)), rd);
         if (sz == 0) expv = uns ? {24'd0, data[7:0]} : {{24{data[7]}}, data[7:0]};
         else if (sz == 1) expv = uns ? {16'd0, data[15:0]} : {{16{data[15]}}, data[15:0]};
         else expv = data;
         chk("rt_load", rd, expv);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
